// File: rtl/ll_telemetry.sv
// Lander telemetry: snapshots altitude/velocity/fuel/thrust/status on sample_i and streams an ASCII frame to the UART.
// Latency: byte 0 is presented the cycle after acceptance; each byte takes 3+GAP_CYCLES cycles with txready_i held high.
// Backpressure: holds txdata_o in SEND while txready_i is low; samples arriving mid-frame are dropped and counted.
module ll_telemetry #(
    parameter bit          EOL_CRLF   = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_i,
    input  logic [15:0] alt_i,
    input  logic [15:0] vel_i,
    input  logic [15:0] fuel_i,
    input  logic [15:0] thrust_i,
    input  logic        land_i,
    input  logic        crash_i,
    input  logic        txready_i,
    output logic [7:0]  txdata_o,
    output logic        txclk_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [7:0]  dropped_o
);

    localparam logic [4:0] LAST_IDX = EOL_CRLF ? 5'd23 : 5'd22;
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_STROBE, S_SETTLE, S_GAP} state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [7:0]  gap_cnt_q;
    logic [7:0]  txdata_q;
    logic        txclk_q;
    logic        busy_q;
    logic        frame_done_q;
    logic [7:0]  dropped_q;
    logic [15:0] alt_q, velmag_q, fuel_q, thrust_q;
    logic        velneg_q;
    logic [7:0]  status_q;

    function automatic logic [7:0] dchar(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    // Digit-serial BCD 0000 - v: nine's complement plus one with decimal carry.
    function automatic logic [15:0] tens_comp(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        logic [4:0]  t;
        logic [4:0]  tm;
        r = 16'h0000;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t  = 5'd9 - {1'b0, v[4*i +: 4]} + {4'h0, c};
            tm = t - 5'd10;
            if (t >= 5'd10) begin
                r[4*i +: 4] = tm[3:0];
                c = 1'b1;
            end else begin
                r[4*i +: 4] = t[3:0];
                c = 1'b0;
            end
        end
        return r;
    endfunction

    logic [4:0] nxt_idx;
    logic [7:0] nxt_byte;
    logic       adv;
    logic       last_byte;
    logic       accept;

    always_comb begin
        nxt_idx  = idx_q + 5'd1;
        nxt_byte = 8'h00;
        case (nxt_idx)
            5'd1:    nxt_byte = dchar(alt_q[15:12]);
            5'd2:    nxt_byte = dchar(alt_q[11:8]);
            5'd3:    nxt_byte = dchar(alt_q[7:4]);
            5'd4:    nxt_byte = dchar(alt_q[3:0]);
            5'd5:    nxt_byte = "V";
            5'd6:    nxt_byte = velneg_q ? "-" : "+";
            5'd7:    nxt_byte = dchar(velmag_q[15:12]);
            5'd8:    nxt_byte = dchar(velmag_q[11:8]);
            5'd9:    nxt_byte = dchar(velmag_q[7:4]);
            5'd10:   nxt_byte = dchar(velmag_q[3:0]);
            5'd11:   nxt_byte = "F";
            5'd12:   nxt_byte = dchar(fuel_q[15:12]);
            5'd13:   nxt_byte = dchar(fuel_q[11:8]);
            5'd14:   nxt_byte = dchar(fuel_q[7:4]);
            5'd15:   nxt_byte = dchar(fuel_q[3:0]);
            5'd16:   nxt_byte = "T";
            5'd17:   nxt_byte = dchar(thrust_q[15:12]);
            5'd18:   nxt_byte = dchar(thrust_q[11:8]);
            5'd19:   nxt_byte = dchar(thrust_q[7:4]);
            5'd20:   nxt_byte = dchar(thrust_q[3:0]);
            5'd21:   nxt_byte = status_q;
            5'd22:   nxt_byte = EOL_CRLF ? 8'h0D : 8'h0A;
            5'd23:   nxt_byte = 8'h0A;
            default: nxt_byte = 8'h00;
        endcase
    end

    // adv marks the final cycle of a byte; on the last byte it is also the back-to-back window.
    assign adv       = (state_q == S_SETTLE && GAP_CYCLES == 0) ||
                       (state_q == S_GAP && gap_cnt_q == GAP_LAST);
    assign last_byte = (idx_q == LAST_IDX);
    assign accept    = sample_i && (state_q == S_IDLE || (adv && last_byte));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 5'd0;
            gap_cnt_q    <= 8'd0;
            txdata_q     <= 8'h00;
            txclk_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= 8'd0;
            alt_q        <= 16'h0000;
            velmag_q     <= 16'h0000;
            fuel_q       <= 16'h0000;
            thrust_q     <= 16'h0000;
            velneg_q     <= 1'b0;
            status_q     <= 8'h00;
        end else begin
            txclk_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (accept) begin
                alt_q    <= alt_i;
                velneg_q <= vel_i[15];
                velmag_q <= vel_i[15] ? tens_comp(vel_i) : vel_i;
                fuel_q   <= fuel_i;
                thrust_q <= thrust_i;
                status_q <= crash_i ? "C" : (land_i ? "L" : "N");
                idx_q    <= 5'd0;
                txdata_q <= "A";
                busy_q   <= 1'b1;
                state_q  <= S_SEND;
            end else if (sample_i && dropped_q != 8'hFF) begin
                dropped_q <= dropped_q + 8'd1;
            end
            case (state_q)
                S_IDLE: ;
                S_SEND: begin
                    if (txready_i) begin
                        state_q <= S_STROBE;
                        txclk_q <= 1'b1;
                    end
                end
                S_STROBE: state_q <= S_SETTLE;
                S_SETTLE, S_GAP: begin
                    if (adv) begin
                        if (last_byte) begin
                            frame_done_q <= 1'b1;
                            if (!accept) begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            idx_q    <= nxt_idx;
                            txdata_q <= nxt_byte;
                            state_q  <= S_SEND;
                        end
                    end else if (state_q == S_SETTLE) begin
                        gap_cnt_q <= 8'd0;
                        state_q   <= S_GAP;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign txdata_o     = txdata_q;
    assign txclk_o      = txclk_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign dropped_o    = dropped_q;

endmodule
